// File: rtl/lfsr_pkg.sv
// Shared constants and the operating-mode enum for the lfsr_unit block.
package lfsr_pkg;

    localparam int LFSR_WIDTH = 8;
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS_DEFAULT = 8'hAA;
    localparam int CNT_W = $clog2(LFSR_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        ADVANCE,
        SERIAL,
        DONE
    } lfsr_mode_t;

endpackage

// File: rtl/lfsr_bit_counter.sv
// Saturating readout bit counter: counts emitted bits up to LIMIT and flags done.
module lfsr_bit_counter
    import lfsr_pkg::*;
#(
    parameter int CW    = CNT_W,
    parameter int LIMIT = LFSR_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          done
);

    assign done = (cnt == CW'(LIMIT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !done) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/lfsr_unit.sv
// Fibonacci LFSR with seed load on reset and LSB-first serial readout.
// Define LFSR_ROTATE_OUT_EN to rotate (rather than zero-fill) the state during readout.
module lfsr_unit
    import lfsr_pkg::*;
#(
    parameter int                WIDTH = LFSR_WIDTH,
    parameter logic [WIDTH-1:0]  TAPS  = LFSR_TAPS_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Enable,
    input  logic             Out_Enable,
    input  logic [WIDTH-1:0] seed,
    output logic             OUT,
    output logic             Valid
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] lfsr;
    logic [CW-1:0]    bit_cnt;
    logic             burst_done;
    logic             fb;
    logic             serial_in;
    lfsr_mode_t       mode;

    // Enable wins over Out_Enable; a finished burst stays silent until the next advance.
    always_comb begin
        mode = IDLE;
        if (Enable) begin
            mode = ADVANCE;
        end else if (Out_Enable) begin
            mode = burst_done ? DONE : SERIAL;
        end
    end

    assign fb = ^(lfsr & TAPS);

`ifdef LFSR_ROTATE_OUT_EN
    assign serial_in = lfsr[0];
`else
    assign serial_in = 1'b0;
`endif

    lfsr_bit_counter #(
        .CW    (CW),
        .LIMIT (WIDTH)
    ) u_bit_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (mode == ADVANCE),
        .inc  (mode == SERIAL),
        .cnt  (bit_cnt),
        .done (burst_done)
    );

    // The seed is reloaded on every edge while reset is held, so late seed changes are captured.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr  <= seed;
            OUT   <= 1'b0;
            Valid <= 1'b0;
        end else begin
            OUT   <= 1'b0;
            Valid <= 1'b0;
            case (mode)
                ADVANCE: lfsr <= {fb, lfsr[WIDTH-1:1]};
                SERIAL: begin
                    OUT   <= lfsr[0];
                    Valid <= 1'b1;
                    lfsr  <= {serial_in, lfsr[WIDTH-1:1]};
                end
                default: lfsr <= lfsr;
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_unit.sv
// Directed self-checking bench for lfsr_unit (default and LFSR_ROTATE_OUT_EN builds).
module tb_lfsr_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       Enable;
    logic       Out_Enable;
    logic [7:0] seed;
    logic       OUT;
    logic       Valid;

    int checks   = 0;
    int failures = 0;

    lfsr_unit dut (
        .clk        (clk),
        .rst        (rst),
        .Enable     (Enable),
        .Out_Enable (Out_Enable),
        .seed       (seed),
        .OUT        (OUT),
        .Valid      (Valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic [7:0] s);
        Enable     = 1'b0;
        Out_Enable = 1'b0;
        seed       = s;
        rst        = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic advance(input int n);
        Enable     = 1'b1;
        Out_Enable = 1'b0;
        repeat (n) tick();
        Enable = 1'b0;
    endtask

    // Collects valid bits LSB-first over a bounded number of cycles.
    task automatic readout(input int ncyc, output logic [7:0] val, output int nv);
        Enable     = 1'b0;
        Out_Enable = 1'b1;
        val        = 8'h00;
        nv         = 0;
        repeat (ncyc) begin
            tick();
            if (Valid === 1'b1) begin
                if (nv < 8) val[nv] = OUT;
                nv++;
            end
        end
        Out_Enable = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        logic [7:0] val;
        int nv;
        Enable     = 1'b0;
        Out_Enable = 1'b1;
        seed       = 8'h93;
        rst        = 1'b0;
        #2;
        checks++;
        if (Valid !== 1'b0 || OUT !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: Valid=%b OUT=%b expected 0/0", Valid, OUT);
        end
        tick();
        seed = 8'h3C;
        tick();
        checks++;
        if (Valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold_valid: Valid=%b expected 0", Valid);
        end
        Out_Enable = 1'b0;
        rst = 1'b1;
        readout(10, val, nv);
        checks++;
        if (val !== 8'h3C || nv != 8) begin
            failures++;
            $display("FAIL reset_seed_load: value=%h bits=%0d expected 3c/8", val, nv);
        end
    endtask

    task automatic test_multi_step();
        logic [7:0] expv;
        logic [7:0] asm;
        logic [7:0] val;
        int nv;
        expv = 8'hAE;
        asm  = 8'h00;
        apply_reset(8'h93);
        advance(10);
        Out_Enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (Valid !== 1'b1 || OUT !== expv[i]) begin
                failures++;
                $display("FAIL multi_bit%0d: Valid=%b OUT=%b expected 1/%b", i, Valid, OUT, expv[i]);
            end
            asm[i] = OUT;
        end
        checks++;
        if (asm !== 8'hAE) begin
            failures++;
            $display("FAIL multi_reassemble: value=%h expected ae", asm);
        end
        tick();
        checks++;
        if (Valid !== 1'b0 || OUT !== 1'b0) begin
            failures++;
            $display("FAIL multi_valid_fall: Valid=%b OUT=%b expected 0/0", Valid, OUT);
        end
        tick();
        checks++;
        if (Valid !== 1'b0) begin
            failures++;
            $display("FAIL multi_saturate: Valid=%b expected 0", Valid);
        end
        Out_Enable = 1'b0;
        tick();
        // After a burst, one advance then a readout: zero-filled state stays 0, rotated state steps.
        advance(1);
        readout(10, val, nv);
        checks++;
`ifdef LFSR_ROTATE_OUT_EN
        if (val !== 8'h57 || nv != 8) begin
            failures++;
            $display("FAIL post_burst_step: value=%h bits=%0d expected 57/8", val, nv);
        end
`else
        if (val !== 8'h00 || nv != 8) begin
            failures++;
            $display("FAIL post_burst_step: value=%h bits=%0d expected 00/8", val, nv);
        end
`endif
    endtask

    task automatic test_single_step();
        logic [7:0] val;
        int nv;
        apply_reset(8'h93);
        advance(1);
        readout(10, val, nv);
        checks++;
        if (val !== 8'h49 || nv != 8) begin
            failures++;
            $display("FAIL single_step: value=%h bits=%0d expected 49/8", val, nv);
        end
    endtask

    task automatic test_zero_seed();
        logic [7:0] val;
        int nv;
        apply_reset(8'h00);
        advance(10);
        readout(12, val, nv);
        checks++;
        if (val !== 8'h00 || nv != 8) begin
            failures++;
            $display("FAIL zero_seed: value=%h bits=%0d expected 00/8", val, nv);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [7:0] val;
        int nv;
        apply_reset(8'h93);
        advance(10);
        Out_Enable = 1'b1;
        repeat (3) tick();
        seed = 8'h5C;
        rst  = 1'b0;
        #1;
        checks++;
        if (Valid !== 1'b0 || OUT !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_burst_outputs: Valid=%b OUT=%b expected 0/0", Valid, OUT);
        end
        Out_Enable = 1'b0;
        tick();
        rst = 1'b1;
        readout(10, val, nv);
        checks++;
        if (val !== 8'h5C || nv != 8) begin
            failures++;
            $display("FAIL reset_mid_burst_reload: value=%h bits=%0d expected 5c/8", val, nv);
        end
    endtask

    task automatic test_enable_priority();
        logic [7:0] val;
        int nv;
        apply_reset(8'h93);
        Enable     = 1'b1;
        Out_Enable = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (Valid !== 1'b0) begin
                failures++;
                $display("FAIL priority_valid%0d: Valid=%b expected 0", i, Valid);
            end
        end
        Enable = 1'b0;
        // Read 3 bits of 0xA4, then an advance cycle aborts the burst.
        repeat (3) tick();
        Enable = 1'b1;
        tick();
        checks++;
        if (Valid !== 1'b0) begin
            failures++;
            $display("FAIL priority_abort_valid: Valid=%b expected 0", Valid);
        end
        readout(10, val, nv);
        checks++;
`ifdef LFSR_ROTATE_OUT_EN
        if (val !== 8'hCA || nv != 8) begin
            failures++;
            $display("FAIL priority_abort_state: value=%h bits=%0d expected ca/8", val, nv);
        end
`else
        if (val !== 8'h0A || nv != 8) begin
            failures++;
            $display("FAIL priority_abort_state: value=%h bits=%0d expected 0a/8", val, nv);
        end
`endif
    endtask

    task automatic test_pause_resume();
        logic [7:0] asm;
        int nv;
        asm = 8'h00;
        nv  = 0;
        apply_reset(8'h93);
        advance(10);
        Out_Enable = 1'b1;
        repeat (3) begin
            tick();
            if (Valid === 1'b1 && nv < 8) begin asm[nv] = OUT; nv++; end
        end
        Out_Enable = 1'b0;
        repeat (2) tick();
        checks++;
        if (Valid !== 1'b0 || OUT !== 1'b0) begin
            failures++;
            $display("FAIL pause_idle: Valid=%b OUT=%b expected 0/0", Valid, OUT);
        end
        Out_Enable = 1'b1;
        repeat (7) begin
            tick();
            if (Valid === 1'b1) begin
                if (nv < 8) asm[nv] = OUT;
                nv++;
            end
        end
        Out_Enable = 1'b0;
        checks++;
        if (asm !== 8'hAE || nv != 8) begin
            failures++;
            $display("FAIL pause_resume: value=%h bits=%0d expected ae/8", asm, nv);
        end
    endtask

    initial begin
        rst        = 1'b0;
        Enable     = 1'b0;
        Out_Enable = 1'b0;
        seed       = 8'h00;
        test_reset();
        test_multi_step();
        test_single_step();
        test_zero_seed();
        test_reset_mid_burst();
        test_enable_priority();
        test_pause_resume();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
